phase_seq_gen: RTL

//  Clocked, parametrised N-phase sequencer; successor of the 3-phase token-ring phase generator.

---
 rtl/phase_seq_pkg.sv | 19 +
 rtl/phase_seq_wdog.sv | 39 +++
 rtl/phase_seq_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - shared types and constants for the N-phase sequencer
// Contents: state encoding (ST_ACTIVE/ST_RELEASE/ST_SPACER), spacer counter width,
//           idx_width() helper returning the phase-index width for a phase count.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_SPACER  = 2'd2
    } state_e;

    localparam int SP_CNT_W = 4;

    // Width of an index able to address n phases; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_seq_wdog.sv
// rtl/phase_seq_wdog.sv - handshake watchdog counter with clear and expire
// Ports: clk, rst (async, active-high), en_i (count this cycle), clr_i (restart count),
//        expire_o (high during the LIMIT-th consecutive enabled cycle).
module phase_seq_wdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of enabled cycles already completed, so the
    // LIMIT-th cycle is the one where cnt_q == LIMIT-1.
    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_seq_gen.sv
// rtl/phase_seq_gen.sv - N-phase one-hot sequencer with return-to-null handshake
// Ports: clk, rst (async, active-high), run_i (allow leaving SPACER), ack_i (stage ack),
//        ph_o (one-hot phase enables), ph_idx_o (current/last phase), busy_o (not in SPACER),
//        rot_cnt_o (completed rotations, wraps), err_o (sticky watchdog error).
// Option: define PHASE_SEQ_TIMEOUT_EN to add the handshake watchdog (phase_seq_wdog).
module phase_seq_gen
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int SPACER_CYCLES  = 2,
    parameter int ROT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run_i,
    input  logic                          ack_i,
    output logic [NUM_PHASES-1:0]         ph_o,
    output logic [$clog2(NUM_PHASES)-1:0] ph_idx_o,
    output logic                          busy_o,
    output logic [ROT_W-1:0]              rot_cnt_o,
    output logic                          err_o
);

    localparam int IDX_W = idx_width(NUM_PHASES);
    localparam logic [SP_CNT_W-1:0] SP_LOAD =
        (SPACER_CYCLES > 0) ? SP_CNT_W'(SPACER_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SP_CNT_W-1:0]   sp_cnt_q, sp_cnt_d;
    logic [ROT_W-1:0]      rot_cnt_q, rot_cnt_d;
    logic [NUM_PHASES-1:0] ph_q, ph_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  advance;
    logic                  wd_expire;

`ifdef PHASE_SEQ_TIMEOUT_EN
    logic wd_en;
    logic wd_clr;

    assign wd_en  = (state_q != ST_SPACER);
    assign wd_clr = (state_d != state_q);

    phase_seq_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sp_cnt_d  = sp_cnt_q;
        rot_cnt_d = rot_cnt_q;
        advance   = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                // A level already high on entry counts as the ack.
                if (ack_i || wd_expire) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_i || wd_expire) begin
                    if (SPACER_CYCLES > 0) begin
                        state_d  = ST_SPACER;
                        sp_cnt_d = SP_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_SPACER: begin
                // run_i only gates the exit; the count runs down regardless.
                if (sp_cnt_q != '0) begin
                    sp_cnt_d = sp_cnt_q - SP_CNT_W'(1);
                end else if (run_i) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase

        if (advance) begin
            state_d = ST_ACTIVE;
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                rot_cnt_d = rot_cnt_q + ROT_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Outputs are decoded from the next state so they leave a flop.
        ph_d   = (state_d == ST_ACTIVE) ? (NUM_PHASES'(1) << idx_d) : '0;
        busy_d = (state_d != ST_SPACER);
        err_d  = err_q | wd_expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACTIVE;
            idx_q     <= '0;
            sp_cnt_q  <= '0;
            rot_cnt_q <= '0;
            ph_q      <= NUM_PHASES'(1);
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sp_cnt_q  <= sp_cnt_d;
            rot_cnt_q <= rot_cnt_d;
            ph_q      <= ph_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign ph_o      = ph_q;
    assign ph_idx_o  = $clog2(NUM_PHASES)'(idx_q);
    assign busy_o    = busy_q;
    assign rot_cnt_o = rot_cnt_q;
    assign err_o     = err_q;

endmodule
